fifo_ctrl: RTL

- Pointer and flag controller that turns the team's dual-port register file (DATA_WIDTH x 2**ADDR_WIDTH, synchronous write, combinational read) into a FIFO.
- Generates the storage write enable and the write/read addresses, and reports occupancy and status to producer and consumer.
- Instantiated beside the register file on keypad/UART message paths, e.g. producer = command parser, consumer = transaction FSM.

---
 rtl/fifo_ctrl_if.sv | 35 +++
 rtl/fifo_ctrl.sv | 69 ++++++
 2 files changed

// File: rtl/fifo_ctrl_if.sv
// FIFO controller handshake bundle.
// Producer/consumer requests in, storage control and status out.
interface fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 2
) ();
  logic                  wr;
  logic                  rd;
  logic                  clr_err;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  wr, rd, clr_err,
    output wr_en, w_addr, r_addr,
    output full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );

  modport master (
    output wr, rd, clr_err,
    input  wr_en, w_addr, r_addr,
    input  full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller turning a dual-port
// register file into a FIFO.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int AFULL_TH   = 3,
  parameter int AEMPTY_TH  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  fifo_ctrl_if.slave f
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH =
    CW'(1 << ADDR_WIDTH);
  localparam logic [CW-1:0] AF = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE = CW'(AEMPTY_TH);

  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [CW-1:0]         cnt;
  logic                  ovf;
  logic                  udf;
  logic                  full;
  logic                  empty;
  logic                  push_ok;
  logic                  pop_ok;

  assign full  = (cnt == DEPTH);
  assign empty = (cnt == '0);

  // A pop at full frees the slot the push lands in.
  assign push_ok = f.wr & (~full | f.rd);
  assign pop_ok  = f.rd & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (push_ok)
        w_ptr <= w_ptr + 1'b1;
      if (pop_ok)
        r_ptr <= r_ptr + 1'b1;
      unique case (1'b1)
        (push_ok & ~pop_ok): cnt <= cnt + 1'b1;
        (pop_ok & ~push_ok): cnt <= cnt - 1'b1;
        default:             cnt <= cnt;
      endcase
      ovf <= (f.wr & ~push_ok)
           | (ovf & ~f.clr_err);
      udf <= (f.rd & ~pop_ok)
           | (udf & ~f.clr_err);
    end
  end

  assign f.wr_en        = push_ok;
  assign f.w_addr       = w_ptr;
  assign f.r_addr       = r_ptr;
  assign f.full         = full;
  assign f.empty        = empty;
  assign f.almost_full  = (cnt >= AF);
  assign f.almost_empty = (cnt <= AE);
  assign f.count        = cnt;
  assign f.overflow     = ovf;
  assign f.underflow    = udf;
endmodule
